// File: rtl/cirno9_biu_arb.sv
// Bus interface arbiter: shares one memory bus between fetch and load/store, with a hung-bus watchdog.
// Optional round-robin grant selected by defining CIRNO_BIU_RR_EN (default: load/store has fixed priority).
module cirno9_biu_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_if4bi_val,
  output logic        hs_bi4if_rdy,
  input  logic [31:0] i_if_adr,
  output logic        hs_bi4if_rsp_val,
  output logic [31:0] o_if_rdat,
  input  logic        hs_ls4bi_val,
  output logic        hs_bi4ls_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic        hs_bi4ls_rsp_val,
  output logic [31:0] o_ls_rdat,
  output logic        o_rsp_err,
  output logic        hs_bi4bus_val,
  input  logic        hs_bus4bi_rdy,
  output logic [31:0] o_bus_adr,
  output logic [31:0] o_bus_wdat,
  output logic [3:0]  o_bus_wen,
  output logic        o_bus_ren,
  input  logic        hs_bus4bi_rsp_val,
  input  logic [31:0] i_bus_rdat,
  input  logic        i_bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner_ls;
  logic        r_last_ls;
  logic [7:0]  r_cnt;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [3:0]  r_wen;
  logic        r_ren;

  logic        w_ls_wins;
  logic        w_gnt_ls;
  logic        w_gnt_if;
  logic        w_accept;
  logic        w_cnt_last;
  logic        w_rsp_fire;
  logic        w_rsp_tmo;
  logic        w_bus_val;

`ifdef CIRNO_BIU_RR_EN
  // On a tie the requester that did not own the last completed transaction wins.
  assign w_ls_wins = hs_ls4bi_val & (~hs_if4bi_val | ~r_last_ls);
`else
  assign w_ls_wins = hs_ls4bi_val;
`endif

  assign w_gnt_ls   = w_ls_wins;
  assign w_gnt_if   = hs_if4bi_val & ~w_ls_wins;
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_rsp_fire   = 1'b0;
    w_rsp_tmo    = 1'b0;
    w_bus_val    = 1'b0;
    hs_bi4if_rdy = 1'b0;
    hs_bi4ls_rdy = 1'b0;
    case (r_state)
      S_IDLE: begin
        hs_bi4if_rdy = w_gnt_if;
        hs_bi4ls_rdy = w_gnt_ls;
        w_accept     = w_gnt_if | w_gnt_ls;
        if (w_accept) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // Bus responses are not expected yet, so only the watchdog can end REQ early.
        if (w_cnt_last) begin
          w_rsp_fire  = 1'b1;
          w_rsp_tmo   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_bus_val = 1'b1;
          if (hs_bus4bi_rdy) w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (hs_bus4bi_rsp_val) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_cnt_last) begin
          w_rsp_fire  = 1'b1;
          w_rsp_tmo   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner_ls <= 1'b0;
      r_last_ls  <= 1'b0;
      r_cnt      <= 8'd0;
      r_adr      <= 32'd0;
      r_wdat     <= 32'd0;
      r_wen      <= 4'd0;
      r_ren      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt      <= 8'd0;
        r_owner_ls <= w_gnt_ls;
        if (w_gnt_ls) begin
          r_adr  <= i_ls_adr;
          r_wdat <= i_ls_wdat;
          r_wen  <= i_ls_wen;
          r_ren  <= i_ls_ren;
        end else begin
          r_adr  <= i_if_adr;
          r_wdat <= 32'd0;
          r_wen  <= 4'd0;
          r_ren  <= 1'b1;
        end
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_rsp_fire) r_last_ls <= r_owner_ls;
    end
  end

  assign hs_bi4bus_val = w_bus_val;
  assign o_bus_adr     = (r_state != S_IDLE) ? r_adr  : 32'd0;
  assign o_bus_wdat    = (r_state != S_IDLE) ? r_wdat : 32'd0;
  assign o_bus_wen     = (r_state != S_IDLE) ? r_wen  : 4'd0;
  assign o_bus_ren     = (r_state != S_IDLE) ? r_ren  : 1'b0;

  // A timeout reports an error with zero data; a real response passes the bus through.
  assign hs_bi4if_rsp_val = w_rsp_fire & ~r_owner_ls;
  assign hs_bi4ls_rsp_val = w_rsp_fire &  r_owner_ls;
  assign o_rsp_err        = w_rsp_fire & (w_rsp_tmo | i_bus_err);
  assign o_if_rdat        = (hs_bi4if_rsp_val & ~w_rsp_tmo) ? i_bus_rdat : 32'd0;
  assign o_ls_rdat        = (hs_bi4ls_rsp_val & ~w_rsp_tmo) ? i_bus_rdat : 32'd0;

endmodule
